// File: rtl/reflet_int_to_float_conv.sv
// -----------------------------------------------------------------------------
// reflet_int_to_float_conv
//
// Converts a signed two's-complement integer into an IEEE-754 binary32 value.
// This block is part of the reflet FPU front end and serves the int->float
// conversion instructions. It has one registered stage and a valid flag that
// travels with the data.
//
// Parameters
//   INT_WIDTH  width of the signed integer operand (2..32)
//
// Ports
//   clk        in   rising-edge system clock
//   reset      in   asynchronous, active-low reset
//   int_in     in   signed integer operand
//   in_valid   in   int_in is sampled on this clock edge
//   float_out  out  binary32 result {sign, exp[7:0], frac[22:0]}
//   out_valid  out  float_out holds a new result this cycle
// -----------------------------------------------------------------------------
module reflet_int_to_float_conv #(
    parameter int INT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [INT_WIDTH-1:0] int_in,
    input  logic                        in_valid,
    output logic [31:0]                 float_out,
    output logic                        out_valid
);

    // One extra bit keeps the magnitude of the most negative operand representable.
    localparam int MW = INT_WIDTH + 1;

    // Index of the most significant set bit. Returns 0 for a zero input; the
    // zero case is handled separately by the caller.
    function automatic logic [5:0] lead_one(input logic [32:0] v);
        logic [5:0] idx;
        idx = '0;
        for (int i = 0; i < 33; i++) begin
            if (v[i]) begin
                idx = 6'(i);
            end
        end
        return idx;
    endfunction

    // Takes the magnitude normalised so its leading one sits at bit 32 and
    // returns {exp[7:0], frac[22:0]} rounded to nearest, ties to even.
    // When the leading one is at index 23 or below, every bit under the kept
    // LSB is zero, so guard and sticky are zero and the result stays exact.
    function automatic logic [30:0] round_pack(input logic [32:0] norm,
                                               input logic [5:0]  lead);
        logic [24:0] mant;
        logic        guard;
        logic        sticky;
        logic        round_up;
        logic [7:0]  exp_b;
        logic [22:0] frac;
        mant     = {1'b0, norm[32:9]};
        guard    = norm[8];
        sticky   = |norm[7:0];
        round_up = guard & (sticky | norm[9]);
        mant     = mant + 25'(round_up);
        exp_b    = 8'd127 + {2'b00, lead};
        if (mant[24]) begin
            // Carry out of the mantissa: the value becomes 1.0 x 2^(p+1).
            frac  = '0;
            exp_b = exp_b + 8'd1;
        end else begin
            frac = mant[22:0];
        end
        return {exp_b, frac};
    endfunction

    logic signed [MW-1:0] ext_p0;
    logic [MW-1:0]        mag_p0;
    logic [32:0]          mag33_p0;
    logic [5:0]           lead_p0;
    logic [32:0]          norm_p0;
    logic                 sign_p0;

    logic [31:0]          float_p1_d;
    logic [31:0]          float_p1_q;
    logic                 vld_p1_d;
    logic                 vld_p1_q;

    // Stage p0: magnitude, leading-one search, normalisation and rounding.
    always_comb begin
        ext_p0     = MW'(int_in);
        sign_p0    = int_in[INT_WIDTH-1];
        mag_p0     = sign_p0 ? $unsigned(-ext_p0) : $unsigned(ext_p0);
        mag33_p0   = 33'(mag_p0);
        lead_p0    = lead_one(mag33_p0);
        norm_p0    = mag33_p0 << (6'd32 - lead_p0);

        float_p1_d = float_p1_q;
        vld_p1_d   = in_valid;
        if (in_valid) begin
            if (mag33_p0 == 33'd0) begin
                // Zero is always +0.0; the sign bit is forced clear.
                float_p1_d = 32'h0000_0000;
            end else begin
                float_p1_d = {sign_p0, round_pack(norm_p0, lead_p0)};
            end
        end
    end

    // Stage p1: registered result and valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            float_p1_q <= 32'h0000_0000;
            vld_p1_q   <= 1'b0;
        end else begin
            float_p1_q <= float_p1_d;
            vld_p1_q   <= vld_p1_d;
        end
    end

    assign float_out = float_p1_q;
    assign out_valid = vld_p1_q;

endmodule

// File: tb/tb_reflet_int_to_float_conv.sv
module tb_reflet_int_to_float_conv;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] in16;
    logic               vld16;
    logic [31:0]        f16;
    logic               ov16;
    logic signed [31:0] in32;
    logic               vld32;
    logic [31:0]        f32;
    logic               ov32;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    reflet_int_to_float_conv #(.INT_WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .int_in(in16), .in_valid(vld16),
        .float_out(f16), .out_valid(ov16)
    );

    reflet_int_to_float_conv #(.INT_WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .int_in(in32), .in_valid(vld32),
        .float_out(f32), .out_valid(ov32)
    );

    // Reference: convert through a double (exact for any 32-bit integer), then
    // round the 53-bit significand to 24 bits, nearest-even.
    function automatic logic [31:0] ref_conv(input longint v);
        logic [63:0] d;
        logic        s;
        int          e;
        logic [52:0] m;
        logic [23:0] keep;
        logic [28:0] rem;
        if (v == 0) return 32'h0;
        d    = $realtobits(real'(v));
        s    = d[63];
        e    = int'(d[62:52]) - 1023;
        m    = {1'b1, d[51:0]};
        keep = m[52:29];
        rem  = m[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && keep[0])) begin
            if (keep == 24'hFF_FFFF) begin
                keep = 24'h80_0000;
                e    = e + 1;
            end else begin
                keep = keep + 24'd1;
            end
        end
        return {s, 8'(e + 127), keep[22:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what each output must show after the latest edge.
    logic [31:0] m_f16 = 32'h0;
    logic        m_v16 = 1'b0;
    logic [31:0] m_f32 = 32'h0;
    logic        m_v32 = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_f16 = 32'h0; m_v16 = 1'b0;
            m_f32 = 32'h0; m_v32 = 1'b0;
        end else begin
            m_v16 = vld16;
            if (vld16) m_f16 = ref_conv(longint'(in16));
            m_v32 = vld32;
            if (vld32) m_f32 = ref_conv(longint'(in32));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_valid16", {31'b0, ov16}, {31'b0, m_v16});
            chk("cmp_float16", f16, m_f16);
            chk("cmp_valid32", {31'b0, ov32}, {31'b0, m_v32});
            chk("cmp_float32", f32, m_f32);
        end
    end

    task automatic lit16(input logic signed [15:0] v, input logic [31:0] e);
        chk("model16_pin", ref_conv(longint'(v)), e);
        in16  = v;
        vld16 = 1'b1;
        @(negedge clk);
        chk("lit16_valid", {31'b0, ov16}, 32'd1);
        chk("lit16_float", f16, e);
    endtask

    task automatic lit32(input logic signed [31:0] v, input logic [31:0] e);
        chk("model32_pin", ref_conv(longint'(v)), e);
        in32  = v;
        vld32 = 1'b1;
        @(negedge clk);
        chk("lit32_valid", {31'b0, ov32}, 32'd1);
        chk("lit32_float", f32, e);
    endtask

    function automatic logic [31:0] rand_val();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = $urandom >> $urandom_range(0, 31);
            2: v = (32'h0100_0000 << $urandom_range(0, 6)) + 32'($urandom_range(0, 300));
            default: begin
                case ($urandom_range(0, 5))
                    0: v = 32'h8000_0000;
                    1: v = 32'h7FFF_FFFF;
                    2: v = 32'h0;
                    3: v = 32'h1;
                    4: v = 32'hFFFF_FFFF;
                    default: v = 32'hFFFF_8000;
                endcase
            end
        endcase
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    initial begin
        logic [31:0] r;
        reset = 1'b1;
        in16 = '0; vld16 = 1'b0;
        in32 = '0; vld32 = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid16", {31'b0, ov16}, 32'd0);
        chk("reset_float16", f16, 32'h0);
        chk("reset_valid32", {31'b0, ov32}, 32'd0);
        chk("reset_float32", f32, 32'h0);
        reset = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Back-to-back directed values on the 16-bit instance.
        lit16(-16'sd6,     32'hC0C0_0000);
        lit16(16'sd134,    32'h4306_0000);
        lit16(-16'sd3457,  32'hC558_1000);
        lit16(16'sd0,      32'h0000_0000);
        lit16(16'sd1,      32'h3F80_0000);
        lit16(-16'sd1,     32'hBF80_0000);
        lit16(16'sh8000,   32'hC700_0000);
        lit16(16'sd32767,  32'h46FF_FE00);
        vld16 = 1'b0;
        in16  = 16'sd5;
        @(negedge clk);
        chk("hold16_valid", {31'b0, ov16}, 32'd0);
        chk("hold16_float", f16, 32'h46FF_FE00);

        // Rounding cases on the 32-bit instance.
        lit32(32'sh7FFF_FFFF, 32'h4F00_0000);
        lit32(32'sd16777217,  32'h4B80_0000);
        lit32(32'sd16777219,  32'h4B80_0002);
        lit32(32'sh8000_0000, 32'hCF00_0000);
        lit32(-32'sd6,        32'hC0C0_0000);
        vld32 = 1'b0;
        @(negedge clk);
        chk("hold32_valid", {31'b0, ov32}, 32'd0);
        chk("hold32_float", f32, 32'hC0C0_0000);

        // Randomised traffic, checked every cycle by the compare process.
        for (int i = 0; i < 400; i++) begin
            r     = rand_val();
            in32  = r;
            in16  = r[15:0];
            vld16 = ($urandom_range(0, 3) != 0);
            vld32 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end

        // Asynchronous reset between edges with work in flight.
        in16 = -16'sd100; vld16 = 1'b1;
        in32 = 32'sd12345; vld32 = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_valid16", {31'b0, ov16}, 32'd0);
        chk("async_float16", f16, 32'h0);
        chk("async_valid32", {31'b0, ov32}, 32'd0);
        chk("async_float32", f32, 32'h0);
        vld16 = 1'b0; vld32 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_valid16", {31'b0, ov16}, 32'd0);
        chk("post_reset_valid32", {31'b0, ov32}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            r     = rand_val();
            in32  = r;
            in16  = r[15:0];
            vld16 = ($urandom_range(0, 1) != 0);
            vld32 = ($urandom_range(0, 1) != 0);
            @(negedge clk);
        end
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
